// File: rtl/video_driver_pkg.sv
// video_driver_pkg: default 640x480@60 timing, colour type and test-pattern bar colours
package video_driver_pkg;

    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int H_TOTAL = 640 + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = 480 + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = '{8'hFF, 8'hFF, 8'hFF};
    localparam rgb_t BAR_YELLOW  = '{8'hFF, 8'hFF, 8'h00};
    localparam rgb_t BAR_CYAN    = '{8'h00, 8'hFF, 8'hFF};
    localparam rgb_t BAR_GREEN   = '{8'h00, 8'hFF, 8'h00};
    localparam rgb_t BAR_MAGENTA = '{8'hFF, 8'h00, 8'hFF};
    localparam rgb_t BAR_RED     = '{8'hFF, 8'h00, 8'h00};
    localparam rgb_t BAR_BLUE    = '{8'h00, 8'h00, 8'hFF};
    localparam rgb_t BAR_BLACK   = '{8'h00, 8'h00, 8'h00};

    function automatic rgb_t bar_colour(input logic [2:0] i);
        return i[2] ? (i[1] ? (i[0] ? BAR_BLACK : BAR_BLUE) : (i[0] ? BAR_RED : BAR_MAGENTA))
                    : (i[1] ? (i[0] ? BAR_GREEN : BAR_CYAN) : (i[0] ? BAR_YELLOW : BAR_WHITE));
    endfunction

endpackage

// File: rtl/video_driver_if.sv
// video_driver_if: pixel request bus (driver publishes x/y, producer returns r/g/b)
interface video_driver_if;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    modport master (output x, y, input r, g, b);
    modport slave (input x, y, output r, g, b);
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel phase, h/v counters, registered coordinates, visible and sync decode
module video_timing_gen
    import video_driver_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int H_FP   = video_driver_pkg::H_FP,
    parameter int H_SYNC = video_driver_pkg::H_SYNC,
    parameter int H_BP   = video_driver_pkg::H_BP,
    parameter int V_FP   = video_driver_pkg::V_FP,
    parameter int V_SYNC = video_driver_pkg::V_SYNC,
    parameter int V_BP   = video_driver_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       phase,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       vis,
    output logic       hs_n,
    output logic       vs_n
);
    localparam logic [9:0] H_LAST = 10'(WIDTH + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(HEIGHT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_ON  = 10'(WIDTH + H_FP);
    localparam logic [9:0] HS_OFF = 10'(WIDTH + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(HEIGHT + V_FP);
    localparam logic [9:0] VS_OFF = 10'(HEIGHT + V_FP + V_SYNC);
    localparam logic [9:0] W      = 10'(WIDTH);
    localparam logic [9:0] H      = 10'(HEIGHT);

    logic [9:0] hcount, vcount, hnext, vnext;

    // counter values for the coming pixel-start edge, and decode of the pixel now in flight
    always_comb begin
        hnext = (hcount == H_LAST) ? '0 : hcount + 10'd1;
        vnext = (hcount != H_LAST) ? vcount : (vcount == V_LAST) ? '0 : vcount + 10'd1;
        vis   = (hcount < W) && (vcount < H);
        hs_n  = !((hcount >= HS_ON) && (hcount < HS_OFF));
        vs_n  = !((vcount >= VS_ON) && (vcount < VS_OFF));
    end

    // phase toggles every cycle; counters and coordinates step when phase goes 1 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= 1'b0;
            hcount <= '0;
            vcount <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                hcount <= hnext;
                vcount <= vnext;
                x      <= (hnext < W) ? hnext : '0;
                y      <= (vnext < H) ? vnext[8:0] : '0;
            end
        end
    end

endmodule

// File: rtl/video_driver.sv
// video_driver: 640x480@60 VGA DAC driver; VIDEO_DRIVER_TEST_PATTERN_EN replaces r/g/b with 8 colour bars
module video_driver
    import video_driver_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int H_FP   = video_driver_pkg::H_FP,
    parameter int H_SYNC = video_driver_pkg::H_SYNC,
    parameter int H_BP   = video_driver_pkg::H_BP,
    parameter int V_FP   = video_driver_pkg::V_FP,
    parameter int V_SYNC = video_driver_pkg::V_SYNC,
    parameter int V_BP   = video_driver_pkg::V_BP
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    video_driver_if.master pix,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N
);
    logic       phase, vis, hs_n, vs_n;
    logic [9:0] x;
    logic [8:0] y;
    rgb_t       src, q;

    video_timing_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(CLOCK_50), .rst(reset), .phase(phase), .x(x), .y(y),
        .vis(vis), .hs_n(hs_n), .vs_n(vs_n)
    );

    assign pix.x = x;
    assign pix.y = y;

    // colour for the pixel currently published on x/y
    always_comb begin
`ifdef VIDEO_DRIVER_TEST_PATTERN_EN
        src = bar_colour(3'(x / 10'(WIDTH / 8)));
`else
        src = {pix.r, pix.g, pix.b};
`endif
    end

    // DAC stage: colour, syncs and blank of the pixel just finished, registered together
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            q           <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (phase) begin
            q           <= vis ? src : '0;
            VGA_HS      <= hs_n;
            VGA_VS      <= vs_n;
            VGA_BLANK_N <= vis;
        end
    end

    assign VGA_R      = q.r;
    assign VGA_G      = q.g;
    assign VGA_B      = q.b;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_video_driver.sv
// tb_video_driver: directed checks of reset, colour path, blanking and h/v timing (short 14-line frame)
module tb_video_driver;
    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       mode     = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    int         vectors = 0;
    int         miscompares = 0;

    video_driver_if pix();

    video_driver #(.HEIGHT(8), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pix(pix),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // producer with one register stage: constant red, green = x, blue = y (or all FF)
    always @(posedge CLOCK_50) begin
        pix.r <= mode ? 8'hFF : 8'h5A;
        pix.g <= mode ? 8'hFF : pix.x[7:0];
        pix.b <= mode ? 8'hFF : pix.y[7:0];
    end

    task step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task do_reset;
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task test_reset;
        #2 reset = 1'b1;
        #1;
        vectors++; if (pix.x !== 10'd0) begin miscompares++; $display("FAIL reset_x got %0d want 0", pix.x); end
        vectors++; if (pix.y !== 9'd0) begin miscompares++; $display("FAIL reset_y got %0d want 0", pix.y); end
        vectors++; if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, VGA_SYNC_N} !== 5'b11000) begin miscompares++; $display("FAIL reset_ctl got %b want 11000", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, VGA_SYNC_N}); end
        vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin miscompares++; $display("FAIL reset_rgb got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        @(negedge CLOCK_50);
        reset = 1'b0;
        mode = 1'b0;
        step(301);
        vectors++; if (pix.x !== 10'd150) begin miscompares++; $display("FAIL midline_x got %0d want 150", pix.x); end
        vectors++; if ({VGA_CLK, VGA_BLANK_N} !== 2'b11) begin miscompares++; $display("FAIL midline_clk_blank got %b want 11", {VGA_CLK, VGA_BLANK_N}); end
        vectors++; if ({VGA_R, VGA_G} !== {8'h5A, 8'd149}) begin miscompares++; $display("FAIL midline_rg got %h want 5a95", {VGA_R, VGA_G}); end
        #2 reset = 1'b1;
        #1;
        vectors++; if ({pix.x, pix.y} !== 19'd0) begin miscompares++; $display("FAIL async_xy got %0d,%0d want 0,0", pix.x, pix.y); end
        vectors++; if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK} !== 4'b1100) begin miscompares++; $display("FAIL async_ctl got %b want 1100", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK}); end
        vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin miscompares++; $display("FAIL async_rgb got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        @(posedge CLOCK_50);
        #1;
        vectors++; if ({pix.x, VGA_CLK} !== 11'd0) begin miscompares++; $display("FAIL held_reset got x=%0d clk=%b want 0,0", pix.x, VGA_CLK); end
    endtask

    task test_colour;
        mode = 1'b0;
        do_reset;
        step(4820);
        vectors++; if ({pix.x, pix.y} !== {10'd10, 9'd3}) begin miscompares++; $display("FAIL colour_xy got %0d,%0d want 10,3", pix.x, pix.y); end
        step(1);
        vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h5A0903) begin miscompares++; $display("FAIL colour_prev got %h want 5a0903", {VGA_R, VGA_G, VGA_B}); end
        step(1);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== {24'h5A0A03, 1'b1}) begin miscompares++; $display("FAIL colour_10_3 got %h blank=%b want 5a0a03 blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N); end
        step(1);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_CLK} !== {24'h5A0A03, 1'b1}) begin miscompares++; $display("FAIL colour_hold got %h clk=%b want 5a0a03 clk=1", {VGA_R, VGA_G, VGA_B}, VGA_CLK); end
    endtask

    task test_blanking;
        int bad;
        mode = 1'b1;
        do_reset;
        step(1281);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== {24'hFFFFFF, 1'b1}) begin miscompares++; $display("FAIL blank_x639 got %h blank=%b want ffffff blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N); end
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            step(1);
            if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== 25'd0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL blank_hporch got %0d bad samples want 0", bad); end
        step(1);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== {24'hFFFFFF, 1'b1}) begin miscompares++; $display("FAIL blank_line1 got %h blank=%b want ffffff blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N); end
        step(11199);
        bad = 0;
        for (int i = 0; i < 9600; i++) begin
            step(1);
            if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== 25'd0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL blank_vporch got %0d bad samples want 0", bad); end
        step(1);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== {24'hFFFFFF, 1'b1}) begin miscompares++; $display("FAIL blank_frame2 got %h blank=%b want ffffff blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N); end
        mode = 1'b0;
    endtask

    task test_pattern;
        do_reset;
        step(2);
        vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin miscompares++; $display("FAIL bar_x0 got %h want ffffff", {VGA_R, VGA_G, VGA_B}); end
        step(160);
        vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFF00) begin miscompares++; $display("FAIL bar_x80 got %h want ffff00", {VGA_R, VGA_G, VGA_B}); end
        step(1118);
        vectors++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N} !== {24'h000000, 1'b1}) begin miscompares++; $display("FAIL bar_x639 got %h blank=%b want 000000 blank=1", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N); end
        step(2);
        vectors++; if (VGA_BLANK_N !== 1'b0) begin miscompares++; $display("FAIL bar_blank got %b want 0", VGA_BLANK_N); end
    endtask

    task test_horizontal;
        int a, b, c, w, h;
        logic c0, c1, c2;
        do_reset;
        a = 0;
        while (VGA_BLANK_N !== 1'b1 && a < 4000) begin step(1); a++; end
        vectors++; if (a !== 2) begin miscompares++; $display("FAIL h_first_pixel got %0d want 2", a); end
        b = 0;
        while (VGA_BLANK_N === 1'b1 && b < 4000) begin step(1); b++; end
        vectors++; if (b !== 1280) begin miscompares++; $display("FAIL h_visible got %0d want 1280", b); end
        c = a + b;
        while (VGA_HS === 1'b1 && c < 4000) begin step(1); c++; end
        vectors++; if (c !== 1314) begin miscompares++; $display("FAIL hs_start got %0d want 1314", c); end
        w = 0;
        while (VGA_HS === 1'b0 && w < 4000) begin step(1); w++; end
        vectors++; if (w !== 192) begin miscompares++; $display("FAIL hs_width got %0d want 192", w); end
        h = 0;
        while (VGA_HS === 1'b1 && h < 4000) begin step(1); h++; end
        vectors++; if (h + w !== 1600) begin miscompares++; $display("FAIL hs_period got %0d want 1600", h + w); end
        w = 0;
        while (VGA_HS === 1'b0 && w < 4000) begin step(1); w++; end
        vectors++; if (w !== 192) begin miscompares++; $display("FAIL hs_width2 got %0d want 192", w); end
        c0 = VGA_CLK;
        step(1);
        c1 = VGA_CLK;
        step(1);
        c2 = VGA_CLK;
        vectors++; if (c1 !== ~c0) begin miscompares++; $display("FAIL vga_clk_toggle got %b after %b want %b", c1, c0, ~c0); end
        vectors++; if (c2 !== c0) begin miscompares++; $display("FAIL vga_clk_period got %b want %b", c2, c0); end
    endtask

    task test_vertical;
        int n, w, h;
        do_reset;
        n = 0;
        while (VGA_VS !== 1'b0 && n < 40000) begin step(1); n++; end
        vectors++; if (n !== 16002) begin miscompares++; $display("FAIL vs_start got %0d want 16002", n); end
        w = 0;
        while (VGA_VS === 1'b0 && w < 40000) begin step(1); w++; end
        vectors++; if (w !== 3200) begin miscompares++; $display("FAIL vs_width got %0d want 3200", w); end
        h = 0;
        while (VGA_VS === 1'b1 && h < 40000) begin step(1); h++; end
        vectors++; if (h + w !== 22400) begin miscompares++; $display("FAIL vs_period got %0d want 22400", h + w); end
    endtask

    initial begin
        test_reset;
`ifdef VIDEO_DRIVER_TEST_PATTERN_EN
        test_pattern;
`else
        test_colour;
        test_blanking;
`endif
        test_horizontal;
        test_vertical;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_driver.md
# video_driver

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz board clock and drives the board's VGA DAC (ADV7123-style) outputs. It publishes the coordinate of the pixel it needs next on `x`/`y` and accepts the colour for that pixel on `r`/`g`/`b`. It sits between the top-level board wrapper and any pixel-generating logic, such as a frame buffer or game renderer.

## Interface
- `WIDTH`, default 640: visible pixels per line.
- `HEIGHT`, default 480: visible lines per frame.
- `H_FP`/`H_SYNC`/`H_BP`, defaults 16/96/48: horizontal front porch, sync and back porch, in pixels.
- `V_FP`/`V_SYNC`/`V_BP`, defaults 10/2/33: vertical front porch, sync and back porch, in lines.
- `CLOCK_50`  in  1: 50 MHz clock, the single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `x`  out  10: column of the requested pixel.
- `y`  out  9: row of the requested pixel.
- `r`, `g`, `b`  in  8 each: colour of the requested pixel.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each: DAC colour.
- `VGA_CLK`  out  1: 25 MHz pixel clock. The DAC samples on its rising edge.
- `VGA_HS`, `VGA_VS`  out  1: syncs, active low.
- `VGA_BLANK_N`  out  1: high only in the visible area.
- `VGA_SYNC_N`  out  1: constant 0 (no sync-on-green).

## Operation
- **Pixel phase:** a 1-bit `phase` toggles every `CLOCK_50` cycle, so one pixel period is 2 cycles. `VGA_CLK` equals `phase`.
- **Counters:** `hcount` (0..799) and `vcount` (0..524) advance on the edge where `phase` goes 1→0.
  - `hcount` wraps at `WIDTH+H_FP+H_SYNC+H_BP-1`.
  - `vcount` increments on the `hcount` wrap and wraps at `HEIGHT+V_FP+V_SYNC+V_BP-1`.
- **Coordinates:** `x` is `hcount` when `hcount < WIDTH`, else 0. `y` is `vcount` when `vcount < HEIGHT`, else 0. Both are registered.
- **Sync and blank, from the counters:**
  - HS is active when `WIDTH+H_FP <= hcount < WIDTH+H_FP+H_SYNC`, i.e. 656..751.
  - VS is active when `vcount` is 490..491.
  - Visible when `hcount < WIDTH` and `vcount < HEIGHT`.
- **Colour pipeline:** at each pixel-start edge the driver registers `VGA_R/G/B`.
  - It loads `r/g/b` when the previous pixel was visible, else 0.
  - `VGA_HS`, `VGA_VS` and `VGA_BLANK_N` are registered alongside, delayed identically, so all DAC outputs stay mutually aligned.
- **Blanking:** RGB outputs are forced to 0 whenever `VGA_BLANK_N` is 0, regardless of `r/g/b`.

## Timing
- `x`/`y` change at pixel-start edge E0. `VGA_CLK` rises at E0+1 cycle.
- `r/g/b` are sampled at E0+2 cycles, the next pixel start. The producer therefore has up to 1 full `CLOCK_50` cycle of registered latency; a single register stage is allowed.
- `VGA_R/G/B`, `VGA_HS`, `VGA_VS` and `VGA_BLANK_N` for coordinate (x, y) appear at E0+2 and hold for 2 cycles. They are stable across the `VGA_CLK` rising edge at E0+3.
- Line length is 800 pixels (1600 cycles). Frame length is 525 lines (840000 cycles).
- **Reset** (asynchronous, any time including mid-frame):
  - `phase`, `hcount`, `vcount`, `x`, `y` and `VGA_CLK` go to 0.
  - `VGA_HS` and `VGA_VS` go to 1.
  - `VGA_BLANK_N` and RGB go to 0.
- **After reset release:** the first pixel (0,0) is presented on `x`/`y` immediately. Normal counting starts at the first `CLOCK_50` edge.

## Configuration
- `VIDEO_DRIVER_TEST_PATTERN_EN` defined: `r/g/b` are ignored. The visible area shows 8 vertical colour bars, each `WIDTH/8` wide, in order white, yellow, cyan, green, magenta, red, blue, black, using 8'hFF/8'h00 components. All timing and blanking are unchanged.
- Undefined: colour comes from `r/g/b` as described above.

## Structure
- **Package `video_driver_pkg`:**
  - default timing constants: `H_FP`, `H_SYNC`, `H_BP`, `V_FP`, `V_SYNC`, `V_BP`, `H_TOTAL`, `V_TOTAL`;
  - the `rgb_t` packed struct (3x8 bits);
  - the test-pattern bar colour constants.
- **Sub-module `video_timing_gen`:** phase, h/v counters, coordinate, visible and sync generation.
- **Top:** the colour/sync output register stage and the test-pattern mux.

## Test plan
- **Reset values:** assert `reset` mid-line. Outputs go immediately to `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0, `x`=0, `y`=0.
- **Horizontal timing:** run 2 lines. `VGA_HS` is low for exactly 192 cycles, starting 656 pixels (1312 cycles + 2-cycle pipeline) after x=0. The period is 1600 cycles. `VGA_CLK` has period 2.
- **Vertical timing:** run a full frame. `VGA_VS` is low for 2 lines (3200 cycles) starting at line 490. Frame period is 840000 cycles.
- **Colour passthrough:** drive `r`=8'h5A, `g`=`x[7:0]` and `b`=`y[7:0]`, each registered by 1 cycle. At the (x, y) = (10, 3) slot, `VGA_R/G/B` = 5A/0A/03 with `VGA_BLANK_N`=1, exactly 2 cycles after `x`=10.
- **Blanking:** hold `r/g/b`=FF during hcount 640..799 and lines 480..524. `VGA_R/G/B`=0 and `VGA_BLANK_N`=0.
- **Test pattern** (with `VIDEO_DRIVER_TEST_PATTERN_EN` defined):
  - x=0 gives FF/FF/FF;
  - x=80 gives FF/FF/00;
  - x=639 gives 00/00/00.
